// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared sizing and types for the FIFO-to-stream read path
package fifo_stream_pkg;
    localparam int FIFO_WIDTH_DEF = 16;
    localparam int SKID_DEPTH = 2;
    typedef logic [1:0] occ_t;
    // A new read is allowed only if the word it brings back is guaranteed a slot.
    function automatic logic has_room(occ_t occ, logic inf, logic pop);
        return ({1'b0, occ} + 3'(inf) - 3'(pop)) < 3'(SKID_DEPTH);
    endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus downstream valid/ready stream
interface fifo_rd_stream_if import fifo_stream_pkg::*; #(parameter int W = FIFO_WIDTH_DEF);
    logic         fifo_empty;
    logic [W-1:0] fifo_data_out;
    logic         fifo_underflow;
    logic         fifo_rd_en;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    modport master (
        input  fifo_empty, fifo_data_out, fifo_underflow, m_ready,
        output fifo_rd_en, m_valid, m_data
    );
    modport slave (
        output fifo_empty, fifo_data_out, fifo_underflow, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry in-order skid buffer with registered head word
module fifo_skid_buf import fifo_stream_pkg::*; #(parameter int W = FIFO_WIDTH_DEF) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output occ_t         occ,
    output logic [W-1:0] head
);
    logic [W-1:0] tail;
    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= '0;
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            occ <= '0;
        end else begin
            occ <= occ + occ_t'(push) - occ_t'(pop);
            // head refills from tail when full, else straight from the incoming word
            if (pop || (push && occ == 2'd0)) head <= (occ == 2'd2) ? tail : din;
            if (push && (pop ? occ == 2'd2 : occ == 2'd1)) tail <= din;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (occ <= 2'(SKID_DEPTH));
            assert (!(push && !pop && occ == 2'(SKID_DEPTH)));
            assert (!(pop && occ == 2'd0));
        end
    end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a FIFO read port into a valid/ready stream with counters
module fifo_rd_stream import fifo_stream_pkg::*; #(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush,
    fifo_rd_stream_if.master     bus,
    output logic [CNT_WIDTH-1:0] word_cnt,
    output logic [7:0]           uflow_cnt
);
    occ_t                  occ;
    logic                  inf;
    logic                  pop;
    logic                  push;
    logic [FIFO_WIDTH-1:0] head;
    assign pop            = bus.m_valid && bus.m_ready;
    assign push           = inf && !flush;
    assign bus.m_valid    = occ != '0;
    assign bus.m_data     = head;
    assign bus.fifo_rd_en = en && !rst && !flush && !bus.fifo_empty && has_room(occ, inf, pop);
    fifo_skid_buf #(.W(FIFO_WIDTH)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(flush),
        .din  (bus.fifo_data_out),
        .occ  (occ),
        .head (head)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            inf       <= 1'b0;
            word_cnt  <= '0;
            uflow_cnt <= '0;
        end else begin
            inf       <= bus.fifo_rd_en;
            word_cnt  <= word_cnt + CNT_WIDTH'(pop);
            uflow_cnt <= uflow_cnt + 8'(bus.fifo_underflow && uflow_cnt != 8'hFF);
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed and randomized checks of fifo_rd_stream
module tb_fifo_rd_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        force_empty = 1'b0;
    logic [15:0] word_cnt;
    logic [7:0]  uflow_cnt;
    int          rptr = 1;
    int          wptr = 1;
    int          checks = 0;
    int          fails = 0;
    int          exp_idx = 19;
    int          pops = 0;
    int          pulses;
    int          n;

    fifo_rd_stream_if #(.W(16)) bus ();

    fifo_rd_stream #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .bus      (bus),
        .word_cnt (word_cnt),
        .uflow_cnt(uflow_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: the word at read index i is simply i
    assign bus.fifo_empty = force_empty || (rptr >= wptr);
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_data_out <= 16'(rptr);
            rptr <= rptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic exp_word(input int w);
        int k = 0;
        while (!bus.m_valid && k < 20) begin
            tick();
            k++;
        end
        chk("word_valid", 32'(bus.m_valid), 1);
        chk("word_data", 32'(bus.m_data), 32'(w));
        tick();
    endtask

    task automatic sb_step();
        #1;
        if (bus.m_valid && bus.m_ready) begin
            chk("sb_data", 32'(bus.m_data), 32'(16'(exp_idx)));
            exp_idx++;
            pops++;
        end
        chk("occ_le2", 32'(u_dut.u_buf.occ <= 2'd2), 1);
    endtask

    initial begin
        bus.m_ready = 1'b1;
        bus.fifo_underflow = 1'b0;
        en = 1'b1;
        wptr = 5;
        tick();
        tick();
        #1;
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 0);
        chk("rst_valid", 32'(bus.m_valid), 0);
        chk("rst_data", 32'(bus.m_data), 0);
        chk("rst_word_cnt", 32'(word_cnt), 0);
        chk("rst_uflow_cnt", 32'(uflow_cnt), 0);
        // streaming 1..4: two-cycle latency then one word per cycle
        rst = 1'b0;
        #1;
        chk("first_rd_en", 32'(bus.fifo_rd_en), 1);
        tick();
        chk("latency_valid", 32'(bus.m_valid), 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("stream_valid", 32'(bus.m_valid), 1);
            chk("stream_data", 32'(bus.m_data), 32'(k));
        end
        tick();
        chk("stream_end_valid", 32'(bus.m_valid), 0);
        chk("stream_word_cnt", 32'(word_cnt), 4);
        // backpressure: words 5..9
        bus.m_ready = 1'b0;
        wptr = wptr + 5;
        #1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            pulses += int'(bus.fifo_rd_en);
            tick();
        end
        chk("bp_rd_pulses", 32'(pulses), 2);
        chk("bp_occ", 32'(u_dut.u_buf.occ), 2);
        chk("bp_valid", 32'(bus.m_valid), 1);
        chk("bp_hold_data", 32'(bus.m_data), 5);
        bus.m_ready = 1'b1;
        for (int w = 5; w <= 9; w++) exp_word(w);
        chk("bp_word_cnt", 32'(word_cnt), 9);
        // flush with one buffered (10) and one in flight (11)
        bus.m_ready = 1'b0;
        wptr = wptr + 4;
        tick();
        tick();
        chk("fl_pre_data", 32'(bus.m_data), 10);
        chk("fl_pre_inf", 32'(u_dut.inf), 1);
        flush = 1'b1;
        #1;
        chk("fl_rd_en", 32'(bus.fifo_rd_en), 0);
        tick();
        chk("fl_valid", 32'(bus.m_valid), 0);
        chk("fl_word_cnt", 32'(word_cnt), 9);
        flush = 1'b0;
        bus.m_ready = 1'b1;
        exp_word(12);
        exp_word(13);
        chk("fl_after_cnt", 32'(word_cnt), 11);
        // flush with a full buffer (14, 15)
        bus.m_ready = 1'b0;
        wptr = wptr + 3;
        repeat (4) tick();
        chk("fl2_occ", 32'(u_dut.u_buf.occ), 2);
        chk("fl2_data", 32'(bus.m_data), 14);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl2_valid", 32'(bus.m_valid), 0);
        bus.m_ready = 1'b1;
        exp_word(16);
        chk("fl2_word_cnt", 32'(word_cnt), 12);
        // reset while 17 is in flight
        bus.m_ready = 1'b0;
        wptr = wptr + 2;
        tick();
        chk("mr_inf", 32'(u_dut.inf), 1);
        rst = 1'b1;
        #1;
        chk("mr_rd_en", 32'(bus.fifo_rd_en), 0);
        tick();
        chk("mr_valid", 32'(bus.m_valid), 0);
        chk("mr_data", 32'(bus.m_data), 0);
        chk("mr_word_cnt", 32'(word_cnt), 0);
        chk("mr_uflow_cnt", 32'(uflow_cnt), 0);
        chk("mr_inf_clr", 32'(u_dut.inf), 0);
        rst = 1'b0;
        bus.m_ready = 1'b1;
        exp_word(18);
        chk("mr_word_cnt2", 32'(word_cnt), 1);
        // underflow saturation
        en = 1'b0;
        bus.m_ready = 1'b0;
        bus.fifo_underflow = 1'b1;
        repeat (254) tick();
        chk("uf_254", 32'(uflow_cnt), 254);
        repeat (46) tick();
        chk("uf_sat", 32'(uflow_cnt), 255);
        bus.fifo_underflow = 1'b0;
        tick();
        chk("uf_hold", 32'(uflow_cnt), 255);
        chk("uf_word_cnt", 32'(word_cnt), 1);
        // randomized en / empty / ready against an in-order scoreboard
        wptr = 32'h4000_0000;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 3) == 0);
            bus.m_ready = ($urandom_range(0, 2) != 0);
            sb_step();
        end
        @(negedge clk);
        en = 1'b0;
        force_empty = 1'b0;
        bus.m_ready = 1'b1;
        sb_step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sb_step();
        end
        chk("sb_no_loss", 32'(exp_idx), 32'(rptr));
        chk("sb_word_cnt", 32'(word_cnt), 32'(16'(1 + pops)));
        // word counter wrap
        en = 1'b1;
        n = 0;
        while (word_cnt != 16'hFFFF && n < 70000) begin
            @(negedge clk);
            n++;
        end
        bus.m_ready = 1'b0;
        chk("wrap_ffff", 32'(word_cnt), 32'h0000FFFF);
        repeat (3) tick();
        chk("wrap_valid", 32'(bus.m_valid), 1);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("wrap_zero", 32'(word_cnt), 0);
        en = 1'b0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter FIFO_WIDTH, 16, data width, which SHALL match the FIFO data width.
REQ-002 Parameter CNT_WIDTH, 16, width of the delivered-word counter.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  1 = fetching allowed; 0 = no new FIFO reads, buffered data still drains.
REQ-006 flush  input  1  synchronous discard of buffered and in-flight words.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid one cycle after an accepted rd_en.
REQ-009 fifo_underflow  input  1  FIFO underflow flag.
REQ-010 fifo_rd_en  output  1  FIFO read request.
REQ-011 m_valid  output  1  downstream word valid.
REQ-012 m_ready  input  1  downstream accept.
REQ-013 m_data  output  FIFO_WIDTH  downstream word.
REQ-014 word_cnt  output  CNT_WIDTH  words delivered (m_valid && m_ready).
REQ-015 uflow_cnt  output  8  FIFO underflow events seen.

Function
REQ-016 Storage SHALL be a 2-entry skid buffer with occupancy occ (0..2) and in-flight flag inf (0..1, set the cycle after fifo_rd_en=1).
REQ-017 pop SHALL be defined as m_valid && m_ready.
REQ-018 fifo_rd_en SHALL be combinational: en && !fifo_empty && !flush && (occ + inf - pop < 2).
REQ-019 A word returning from the FIFO SHALL be written into the buffer on the cycle inf=1, unless flush=1 on that cycle.
REQ-020 m_valid SHALL equal (occ != 0); m_data SHALL be the oldest buffered word, registered, never from fifo_data_out directly.
REQ-021 While m_valid=1 && m_ready=0, m_valid and m_data SHALL stay stable.
REQ-022 Sustained throughput SHALL be 1 word/cycle when the FIFO is non-empty and m_ready=1, after a 2-cycle initial latency (rd_en to m_valid).
REQ-023 A simultaneous write and pop SHALL leave occ unchanged with order preserved; with occ=2, rd_en SHALL assert only if pop=1 the same cycle.
REQ-024 flush=1 SHALL set occ=0, drop any in-flight word, and force m_valid=0 on the next cycle; counters SHALL be unaffected.
REQ-025 word_cnt SHALL increment by 1 on each pop and wrap modulo 2^CNT_WIDTH.
REQ-026 uflow_cnt SHALL increment on each cycle fifo_underflow=1 and saturate at 255.
REQ-027 Overflow of the skid buffer SHALL be impossible by construction; an assertion SHALL check occ <= 2.

Reset
REQ-028 On rst=1 at a clock edge, occ=0, inf=0, m_valid=0, m_data=0, word_cnt=0, uflow_cnt=0.
REQ-029 fifo_rd_en SHALL be 0 whenever rst=1.
REQ-030 Reset mid-transfer SHALL discard the in-flight word; the first read after reset SHALL occur no earlier than the first cycle with rst=0.

Structure
REQ-031 Package fifo_stream_pkg SHALL hold FIFO_WIDTH default, SKID_DEPTH=2, and the occupancy typedef (2-bit).
REQ-032 The 2-entry buffer SHALL be a sub-module fifo_skid_buf (push, pop, flush, occ, head data); the top level holds rd_en logic and counters.

Verification
REQ-033 FIFO holds 0x0001..0x0004, m_ready=1, en=1 -> m_data 0x0001..0x0004 on 4 consecutive cycles, first one 2 cycles after the first rd_en; word_cnt=4.
REQ-034 m_ready=0 with FIFO non-empty -> exactly 2 rd_en pulses, occ=2, m_data held at the first word; m_ready=1 resumes in order with no loss or duplication.
REQ-035 flush while occ=2 and inf=1 -> m_valid=0 next cycle; discarded words never appear; word_cnt unchanged.
REQ-036 rst asserted while inf=1 -> all outputs 0 next cycle; after release the next word comes fresh from the FIFO.
REQ-037 fifo_underflow held for 300 cycles -> uflow_cnt saturates at 255; word_cnt=0xFFFF plus one pop -> 0x0000.
REQ-038 Random m_ready/en/fifo_empty for 10k cycles -> scoreboard matches FIFO order exactly; occ never exceeds 2.
